// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit for the RV32IC core. It forms the effective
// address base + offset (wrapping modulo 2^32) and performs one byte,
// halfword or word access on the data memory. Load results come back as a
// registered write-back that the register file samples on the falling edge.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           request pulse from execute, sampled only while idle
//   is_load         1 = load, 0 = store
//   funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   base, offset    rs1 value and sign-extended immediate
//   store_data      rs2 value
//   rd_in           load destination register
//   busy            high whenever the unit is not idle
//   done            one-cycle completion pulse
//   fault           one-cycle pulse with done for misaligned/illegal accesses
//   wb_en/rd/data   register-file write port (wb_en suppressed for x0)
//   mem_*           data-memory request channel
//   dbgState        current FSM state (IDLE=0, REQ=1, DONE=2, FAULT=3)
//
// Memory handshake: mem_req rises with mem_addr/mem_be/mem_we/mem_wdata
// already valid and all of them stay frozen until the first cycle in which
// mem_ack is sampled high; that cycle also carries valid mem_rdata and
// completes the transfer. mem_ack is ignored whenever mem_req is low.
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_load,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] base,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] store_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic            fault,
   output logic            wb_en,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [1:0]      dbgState
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] FAULT = 2'd3;

   logic [1:0]      state;

   // Request context captured at start; only what the load path needs later.
   logic [1:0]      laneQ;
   logic [2:0]      funct3Q;
   logic            isLoadQ;
   logic [4:0]      rdQ;

   logic [XLEN-1:0] ea;
   logic            isHalf;
   logic            isWord;
   logic            illegalOp;
   logic            misaligned;
   logic            accessFault;
   logic [3:0]      beNext;
   logic [XLEN-1:0] wdataNext;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] loadResult;

   assign dbgState = state;

   // Address decode and store-lane formatting, evaluated on the live inputs
   // so everything can be registered in the start cycle.
   always_comb begin
      ea          = base + offset;
      isHalf      = (funct3[1:0] == 2'b01);
      isWord      = (funct3 == 3'b010);
      // 011, 11x are undefined; BU/HU only make sense as loads.
      illegalOp   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                    (!is_load && funct3[2]);
      misaligned  = (isHalf && ea[0]) || (isWord && (ea[1:0] != 2'b00));
      accessFault = illegalOp || misaligned;

      beNext    = 4'b1111;
      wdataNext = store_data;
      case (funct3[1:0])
         2'b00: begin
            beNext    = 4'b0001 << ea[1:0];
            wdataNext = {4{store_data[7:0]}};
         end
         2'b01: begin
            beNext    = 4'b0011 << ea[1:0];
            wdataNext = {2{store_data[15:0]}};
         end
         default: begin
            beNext    = 4'b1111;
            wdataNext = store_data;
         end
      endcase
   end

   // Load extraction: move the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted = mem_rdata >> {laneQ, 3'b000};
      case (funct3Q)
         3'b000:  loadResult = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  loadResult = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  loadResult = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  loadResult = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: loadResult = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
         wb_en     <= 1'b0;
         wb_rd     <= 5'd0;
         wb_data   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= '0;
         laneQ     <= 2'b00;
         funct3Q   <= 3'b000;
         isLoadQ   <= 1'b0;
         rdQ       <= 5'd0;
      end else begin
         // Pulse outputs default low; they are raised for exactly one cycle.
         done  <= 1'b0;
         fault <= 1'b0;
         wb_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  laneQ   <= ea[1:0];
                  funct3Q <= funct3;
                  isLoadQ <= is_load;
                  rdQ     <= rd_in;
                  busy    <= 1'b1;
                  if (accessFault) begin
                     // Faulting accesses never touch memory.
                     state <= FAULT;
                     done  <= 1'b1;
                     fault <= 1'b1;
                  end else begin
                     state     <= REQ;
                     mem_req   <= 1'b1;
                     mem_we    <= !is_load;
                     mem_addr  <= {ea[XLEN-1:2], 2'b00};
                     mem_be    <= beNext;
                     mem_wdata <= wdataNext;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done    <= 1'b1;
                  if (isLoadQ) begin
                     // x0 loads still access memory; only the write is dropped.
                     wb_en   <= (rdQ != 5'd0);
                     wb_rd   <= rdQ;
                     wb_data <= loadResult;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            FAULT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A behavioural model derives the
// expected address, byte enables, store lanes, fault flag and load result
// straight from the access rules with byte-level arithmetic; directed
// scenarios cover the documented corner cases and a randomized loop covers
// the rest. Inputs are driven on the falling edge, outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] base = 32'd0;
   logic [31:0] offset = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        busy, done, fault, wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic [1:0]  dbgState;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];

   load_store_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .funct3(funct3),
      .base(base), .offset(offset), .store_data(store_data), .rd_in(rd_in),
      .busy(busy), .done(done), .fault(fault), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .dbgState(dbgState)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] wbData;
      logic        isFault;
   } model_t;

   function automatic model_t refModel(input bit ld, input bit [2:0] f3,
                                       input bit [31:0] b, input bit [31:0] o,
                                       input bit [31:0] sd, input bit [31:0] rdata);
      model_t m;
      int unsigned ea, lane, size;
      bit illegal;
      longint unsigned v;
      ea   = b + o;
      lane = ea % 4;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      illegal   = (size == 0) || (!ld && f3 >= 3'd4);
      m.isFault = illegal || ((size != 0) && (ea % size != 0));
      m.addr    = ea - lane;
      m.be      = 4'b0000;
      m.wdata   = 32'd0;
      for (int k = 0; k < 4; k++) begin
         if (size != 0 && k >= int'(lane) && k < int'(lane + size)) m.be[k] = 1'b1;
         if (size != 0) m.wdata[8*k +: 8] = sd[8*(k % size) +: 8];
      end
      v = 0;
      for (int i = 0; i < int'(size); i++)
         v = v + (((longint'(rdata) >> (8*(lane + i))) & 64'hFF) << (8*i));
      if (size != 0 && size < 4 && f3 < 3'd4 && ((v >> (8*size - 1)) & 1) == 1)
         v = (v + 64'h1_0000_0000 - (64'd1 << (8*size))) & 64'hFFFF_FFFF;
      m.wbData = v[31:0];
      return m;
   endfunction

   // ---------------- driver ----------------
   // Observations of the most recent access, compared by the test tasks.
   logic        obsReqEver, obsWe, obsDone, obsFault, obsWbEn, obsStable;
   logic        obsIdleAfter, obsReqAfter;
   logic [31:0] obsAddr, obsWdata, obsWbData;
   logic [3:0]  obsBe;
   logic [4:0]  obsWbRd;
   int          obsReqCycles;

   // Called at a falling edge with the DUT idle; returns at a falling edge
   // with the DUT idle again, so consecutive calls are back-to-back.
   task automatic run_access(input bit ld, input bit [2:0] f3, input bit [31:0] b,
                             input bit [31:0] o, input bit [31:0] sd,
                             input bit [4:0] rd, input bit [31:0] rdata,
                             input int waits);
      start = 1'b1; is_load = ld; funct3 = f3; base = b; offset = o;
      store_data = sd; rd_in = rd;
      @(negedge clk);
      // Scramble operands to show they were latched at start.
      start = 1'b0; base = $urandom; offset = $urandom; store_data = $urandom;
      rd_in = 5'($urandom); funct3 = 3'($urandom); is_load = 1'($urandom);
      obsReqEver = mem_req; obsAddr = mem_addr; obsBe = mem_be; obsWe = mem_we;
      obsWdata = mem_wdata; obsDone = done; obsFault = fault; obsWbEn = wb_en;
      obsWbRd = wb_rd; obsWbData = wb_data; obsReqAfter = 1'b0;
      obsReqCycles = 0; obsStable = 1'b1;
      if (mem_req) begin
         obsReqCycles = 1;
         for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            if (mem_req) obsReqCycles++;
            if (mem_addr !== obsAddr || mem_be !== obsBe || mem_we !== obsWe ||
                mem_wdata !== obsWdata) obsStable = 1'b0;
         end
         mem_ack = 1'b1; mem_rdata = rdata;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = $urandom;
         obsDone = done; obsFault = fault; obsWbEn = wb_en; obsWbRd = wb_rd;
         obsWbData = wb_data; obsReqAfter = mem_req;
      end
      @(negedge clk);
      obsIdleAfter = !busy && !done && !mem_req && (dbgState == 2'd0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b1; mem_ack = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b fault=%b wb_en=%b required all 0", busy, done, fault, wb_en); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0) begin errors++; $display("FAIL reset_mem: req=%b we=%b be=%b required 0", mem_req, mem_we, mem_be); end
      checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin errors++; $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h wb_rd=%0d required 0", mem_addr, mem_wdata, wb_data, wb_rd); end
      checks++; if (dbgState !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbgState); end
      rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw_basic();
      run_access(1'b1, 3'b010, 32'h1000, 32'd4, 32'd0, 5'd5, 32'hDEADBEEF, 0);
      checks++; if (obsAddr !== 32'h1004) begin errors++; $display("FAIL lw_addr: got %h required 00001004", obsAddr); end
      checks++; if (obsBe !== 4'b1111 || obsWe !== 1'b0) begin errors++; $display("FAIL lw_be_we: be=%b we=%b required 1111/0", obsBe, obsWe); end
      checks++; if (obsDone !== 1'b1 || obsWbEn !== 1'b1 || obsFault !== 1'b0) begin errors++; $display("FAIL lw_done: done=%b wb_en=%b fault=%b required 1/1/0", obsDone, obsWbEn, obsFault); end
      checks++; if (obsWbData !== 32'hDEADBEEF || obsWbRd !== 5'd5) begin errors++; $display("FAIL lw_data: data=%h rd=%0d required deadbeef/5", obsWbData, obsWbRd); end
      checks++; if (obsReqCycles != 1 || obsReqAfter !== 1'b0 || obsIdleAfter !== 1'b1) begin errors++; $display("FAIL lw_timing: req_cycles=%0d req_after=%b idle_after=%b required 1/0/1", obsReqCycles, obsReqAfter, obsIdleAfter); end
   endtask

   task automatic test_lb_lbu();
      run_access(1'b1, 3'b000, 32'h2000, 32'd3, 32'd0, 5'd7, 32'h80112233, 1);
      checks++; if (obsWbData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h required ffffff80", obsWbData); end
      checks++; if (obsBe !== 4'b1000 || obsAddr !== 32'h2000) begin errors++; $display("FAIL lb_be_addr: be=%b addr=%h required 1000/00002000", obsBe, obsAddr); end
      run_access(1'b1, 3'b100, 32'h2000, 32'd3, 32'd0, 5'd7, 32'h80112233, 0);
      checks++; if (obsWbData !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h required 00000080", obsWbData); end
   endtask

   task automatic test_sh_wait();
      run_access(1'b0, 3'b001, 32'h3000, 32'd2, 32'h0000ABCD, 5'd9, 32'h0, 3);
      checks++; if (obsWe !== 1'b1 || obsBe !== 4'b1100) begin errors++; $display("FAIL sh_we_be: we=%b be=%b required 1/1100", obsWe, obsBe); end
      checks++; if (obsWdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h required abcdabcd", obsWdata); end
      checks++; if (obsReqCycles != 4 || obsStable !== 1'b1) begin errors++; $display("FAIL sh_hold: req_cycles=%0d stable=%b required 4/1", obsReqCycles, obsStable); end
      checks++; if (obsDone !== 1'b1 || obsWbEn !== 1'b0 || obsFault !== 1'b0) begin errors++; $display("FAIL sh_done: done=%b wb_en=%b fault=%b required 1/0/0", obsDone, obsWbEn, obsFault); end
   endtask

   task automatic test_misaligned();
      run_access(1'b1, 3'b010, 32'h4000, 32'd1, 32'd0, 5'd3, 32'h12345678, 0);
      checks++; if (obsDone !== 1'b1 || obsFault !== 1'b1 || obsWbEn !== 1'b0) begin errors++; $display("FAIL misaligned_flags: done=%b fault=%b wb_en=%b required 1/1/0", obsDone, obsFault, obsWbEn); end
      checks++; if (obsReqEver !== 1'b0 || obsIdleAfter !== 1'b1) begin errors++; $display("FAIL misaligned_noreq: req=%b idle_after=%b required 0/1", obsReqEver, obsIdleAfter); end
      // A store with an unsigned-load funct3 is illegal.
      run_access(1'b0, 3'b101, 32'h5000, 32'd0, 32'h1, 5'd0, 32'h0, 0);
      checks++; if (obsFault !== 1'b1 || obsDone !== 1'b1 || obsReqEver !== 1'b0) begin errors++; $display("FAIL illegal_store: fault=%b done=%b req=%b required 1/1/0", obsFault, obsDone, obsReqEver); end
   endtask

   task automatic test_start_in_req_then_reset();
      start = 1'b1; is_load = 1'b1; funct3 = 3'b010; base = 32'h5000; offset = 32'd0; rd_in = 5'd4;
      @(negedge clk);
      start = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h5000) begin errors++; $display("FAIL rq_first: req=%b addr=%h required 1/00005000", mem_req, mem_addr); end
      start = 1'b1; is_load = 1'b0; base = 32'h6000; funct3 = 3'b000;
      @(negedge clk);
      start = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h5000 || mem_we !== 1'b0 || mem_be !== 4'b1111) begin errors++; $display("FAIL rq_second_start: req=%b addr=%h we=%b be=%b required 1/00005000/0/1111", mem_req, mem_addr, mem_we, mem_be); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || dbgState !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL rq_reset: req=%b busy=%b state=%0d done=%b required 0/0/0/0", mem_req, busy, dbgState, done); end
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (done !== 1'b0 || wb_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rq_late_ack: done=%b wb_en=%b busy=%b required 0/0/0", done, wb_en, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rq_late_ack2: done=%b req=%b required 0/0", done, mem_req); end
   endtask

   task automatic test_wrap_x0();
      run_access(1'b1, 3'b010, 32'hFFFFFFFC, 32'd8, 32'd0, 5'd0, 32'h55AA55AA, 0);
      checks++; if (obsAddr !== 32'h00000004 || obsReqEver !== 1'b1) begin errors++; $display("FAIL wrap_addr: addr=%h req=%b required 00000004/1", obsAddr, obsReqEver); end
      checks++; if (obsDone !== 1'b1 || obsWbEn !== 1'b0) begin errors++; $display("FAIL x0_wb: done=%b wb_en=%b required 1/0", obsDone, obsWbEn); end
   endtask

   task automatic test_back_to_back();
      model_t m;
      m = refModel(1'b0, 3'b000, 32'h7000, 32'd1, 32'h000000A5, 32'h0);
      run_access(1'b0, 3'b000, 32'h7000, 32'd1, 32'h000000A5, 5'd1, 32'h0, 0);
      checks++; if (obsWdata !== m.wdata || obsBe !== m.be) begin errors++; $display("FAIL b2b_sb: wdata=%h be=%b required %h/%b", obsWdata, obsBe, m.wdata, m.be); end
      m = refModel(1'b1, 3'b101, 32'h7000, 32'd2, 32'h0, 32'hBEEF1234);
      run_access(1'b1, 3'b101, 32'h7000, 32'd2, 32'h0, 5'd2, 32'hBEEF1234, 0);
      checks++; if (obsDone !== 1'b1 || obsWbData !== m.wbData) begin errors++; $display("FAIL b2b_lhu: done=%b data=%h required 1/%h", obsDone, obsWbData, m.wbData); end
   endtask

   task automatic test_random();
      model_t m;
      bit ld;
      bit [2:0] f3;
      bit [31:0] b, o, sd, rdata;
      bit [4:0] rd;
      int waits;
      logic [31:0] expData;
      for (int n = 0; n < 60; n++) begin
         ld = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         b = $urandom; o = $urandom; sd = $urandom; rdata = $urandom;
         rd = 5'($urandom_range(0, 31));
         waits = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin b[1:0] = 2'b00; o[1:0] = 2'b00; end
         m = refModel(ld, f3, b, o, sd, rdata);
         run_access(ld, f3, b, o, sd, rd, rdata, waits);
         if (m.isFault) begin
            checks++; if (obsFault !== 1'b1 || obsDone !== 1'b1 || obsReqEver !== 1'b0 || obsWbEn !== 1'b0) begin errors++; $display("FAIL rnd_fault[%0d]: fault=%b done=%b req=%b wb_en=%b required 1/1/0/0", n, obsFault, obsDone, obsReqEver, obsWbEn); end
         end else begin
            checks++; if (obsAddr !== m.addr || obsBe !== m.be || obsWe !== !ld) begin errors++; $display("FAIL rnd_req[%0d]: addr=%h be=%b we=%b required %h/%b/%b", n, obsAddr, obsBe, obsWe, m.addr, m.be, !ld); end
            checks++; if (obsReqCycles != waits + 1 || obsStable !== 1'b1 || obsDone !== 1'b1 || obsFault !== 1'b0) begin errors++; $display("FAIL rnd_hs[%0d]: req_cycles=%0d stable=%b done=%b fault=%b required %0d/1/1/0", n, obsReqCycles, obsStable, obsDone, obsFault, waits + 1); end
            checks++; if (obsWbEn !== (ld && rd != 5'd0)) begin errors++; $display("FAIL rnd_wb_en[%0d]: got %b required %b", n, obsWbEn, (ld && rd != 5'd0)); end
            if (ld) begin
               exp_q.push_back(m.wbData);
               expData = exp_q.pop_front();
               checks++; if (obsWbData !== expData || obsWbRd !== rd) begin errors++; $display("FAIL rnd_load[%0d]: data=%h rd=%0d required %h/%0d", n, obsWbData, obsWbRd, expData, rd); end
            end else begin
               checks++; if (obsWdata !== m.wdata) begin errors++; $display("FAIL rnd_store[%0d]: wdata=%h required %h", n, obsWdata, m.wdata); end
            end
         end
         checks++; if (obsIdleAfter !== 1'b1) begin errors++; $display("FAIL rnd_idle[%0d]: not idle after completion", n); end
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      @(negedge clk);
      test_reset();
      test_lw_basic();
      test_lb_lbu();
      test_sh_wait();
      test_misaligned();
      test_start_in_req_then_reset();
      test_wrap_x0();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the RV32IC core. It takes rs1/rs2 operands read from the register file plus the decoded immediate, and performs one byte, halfword or word data-memory access over a req/ack handshake. Loads are returned as a registered write-back (rd, data, enable) that the register file samples on the falling clock edge. It sits between execute and the data memory and feeds the register-file write port.

## Interface
- XLEN, 32, data and address width (only 32 supported)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request pulse from execute; sampled only in IDLE
- is_load  in  1  1 = load, 0 = store
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- base  in  32  rs1 value
- offset  in  32  sign-extended immediate
- store_data  in  32  rs2 value
- rd_in  in  5  load destination register
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse with done: misaligned or illegal funct3
- wb_en  out  1  register-file write enable, one cycle
- wb_rd  out  5  write-back register index
- wb_data  out  32  extended load result
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] = 00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  memory accept/complete; meaningful only while mem_req = 1
- mem_rdata  in  32  read data, valid in the mem_ack cycle

## Operation
- ea = base + offset, computed modulo 2^32. Carry out is discarded; wrap-around is legal.
- States: IDLE, REQ, DONE, FAULT.
- IDLE + start: latch ea, funct3, is_load, store_data and rd_in.
  - Go to FAULT if the access is misaligned or illegal, otherwise go to REQ.
  - Misaligned: H/HU with ea[0]=1; W with ea[1:0] != 00.
  - Illegal: funct3 = 011, 110 or 111, or a store with funct3 = 100 or 101.
- start is ignored while not in IDLE; operands are not re-latched.
- REQ: mem_req = 1, with mem_addr = {ea[31:2],2'b00} and mem_we = !is_load.
  - All memory outputs stay constant until mem_ack. On ack, capture mem_rdata and go to DONE.
- Byte enables: B = 0001 << ea[1:0]; H = 0011 << ea[1:0]; W = 1111. Loads drive the same be pattern.
- Store data:
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: unchanged.
- Load data: shift mem_rdata right by ea[1:0]×8, then extend.
  - B and H sign-extend from bit 7 / bit 15.
  - BU and HU zero-extend.
- DONE: done = 1. For a load, wb_en = (wb_rd != 0), wb_rd = latched rd, wb_data = extended result. For a store, wb_en = 0. Next state is IDLE.
- FAULT: done = 1 and fault = 1, wb_en = 0, no memory access issued. Next state is IDLE.
- Loads to x0 still perform the memory access; only the write-back is suppressed.

## Timing
- All outputs are registered.
- Reset values: busy, done, fault, wb_en, mem_req, mem_we = 0; wb_rd = 0; wb_data, mem_addr, mem_be, mem_wdata = 0; state = IDLE.
- Latency with mem_ack in the first REQ cycle:
  - start sampled at edge 0;
  - mem_req high during cycle 1;
  - done and wb_en high during cycle 2.
  - Each wait cycle adds one cycle.
- Fault latency: done/fault high in the cycle after start.
- wb_en, wb_rd and wb_data are stable for the whole DONE cycle, so the register file's negedge write samples them correctly.
- Back-to-back: a new start is accepted in the cycle after DONE (state == IDLE).
- rst asserted in any state: at the next rising edge the block returns to IDLE and all outputs take their reset values. An in-flight mem_req is dropped without waiting for ack. A mem_ack arriving after reset is ignored.
- mem_ack while mem_req = 0: ignored.

## Test plan
- LW, base = 0x1000, offset = 4, mem_rdata = 0xDEADBEEF, ack immediate:
  - mem_addr = 0x1004, mem_be = 1111;
  - two cycles after start: done = 1, wb_en = 1, wb_data = 0xDEADBEEF.
- LB at ea = 0x2003, mem_rdata = 0x80112233: wb_data = 0xFFFFFF80. LBU at the same address: wb_data = 0x00000080.
- SH at ea = 0x3002, store_data = 0x0000ABCD, ack after 3 wait cycles:
  - mem_we = 1, mem_be = 1100, mem_wdata = 0xABCDABCD;
  - mem_req held for 4 cycles; done with wb_en = 0.
- LW at ea = 0x4001:
  - next cycle done = 1, fault = 1, wb_en = 0;
  - mem_req never asserted.
- start pulsed again while in REQ, then rst asserted during REQ:
  - the second start has no effect;
  - after the reset edge, mem_req = 0, busy = 0 and state = IDLE;
  - a late mem_ack produces no done.
- LW with rd_in = 0 and base + offset = 0xFFFFFFFC + 8:
  - mem_addr = 0x00000004 (wrap-around);
  - done = 1, wb_en = 0.
